// File: rtl/fp_dot_accumulate.sv
// Streaming dot-product reduction: sums each group of VEC_LEN single-precision
// products with a single-cycle FP adder and emits one result pulse per group.
module fp_dot_accumulate #(
  parameter int VEC_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             validIn,
  input  logic [31:0]      dataIn,
  output logic [31:0]      dataOut,
  output logic             validOut,
  output logic [CNT_W-1:0] countOut,
  output logic             busyOut
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // IEEE-754 single add, flush-to-zero in and out, RNE with guard/round/sticky.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, s1, s2;
    logic [7:0]  ea, eb, e1, e2, d;
    logic [22:0] fa, fb, f1, f2;
    logic        za, zb, na, nb, ia, ib;
    logic [26:0] mx, my, mm;
    logic [53:0] ext;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic        found, rup, zres;
    logic signed [9:0] e;
    logic [24:0] mr;
    logic [31:0] res;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    za = (ea == 8'h00); zb = (eb == 8'h00);
    na = (ea == 8'hFF) && (fa != 23'd0); nb = (eb == 8'hFF) && (fb != 23'd0);
    ia = (ea == 8'hFF) && (fa == 23'd0); ib = (eb == 8'hFF) && (fb == 23'd0);
    res = 32'h0; mm = 27'd0; sum = 28'd0; lz = 5'd0; found = 1'b0; zres = 1'b0;
    if ({ea, fa} >= {eb, fb}) begin
      s1 = sa; e1 = ea; f1 = fa; s2 = sb; e2 = eb; f2 = fb;
    end else begin
      s1 = sb; e1 = eb; f1 = fb; s2 = sa; e2 = ea; f2 = fa;
    end
    d = e1 - e2;
    if (d > 8'd31) d = 8'd31;
    mx = {1'b1, f1, 3'b000};
    ext = {1'b1, f2, 3'b000, 27'd0} >> d;
    my = {ext[53:28], ext[27] | (|ext[26:0])};
    e = $signed({2'b00, e1});
    if (s1 == s2) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        mm = {sum[27:2], sum[1] | sum[0]};
        e  = e + 10'sd1;
      end else begin
        mm = sum[26:0];
      end
    end else begin
      sum = {1'b0, mx - my};
      zres = (sum[26:0] == 27'd0);
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz = 5'(26 - i);
          found = 1'b1;
        end
      end
      mm = sum[26:0] << lz;
      e  = e - $signed({5'b00000, lz});
    end
    rup = mm[2] & (mm[1] | mm[0] | mm[3]);
    mr  = {1'b0, mm[26:3]} + {24'd0, rup};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (na || nb || (ia && ib && (sa != sb))) res = QNAN;
    else if (ia)                              res = a;
    else if (ib)                              res = b;
    else if (za && zb)                        res = {sa & sb, 31'd0};
    else if (za)                              res = b;
    else if (zb)                              res = a;
    else if (zres)                            res = 32'h0;
    else if (e >= 10'sd255)                   res = {s1, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                     res = 32'h0;
    else                                      res = {s1, e[7:0], mr[22:0]};
    return res;
  endfunction

  logic [31:0]      r_acc, r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld;
  logic [31:0]      w_sum;
  logic             w_last, w_first;

  assign w_sum   = fp_add(r_acc, dataIn);
  assign w_last  = (r_cnt == CNT_W'(VEC_LEN - 1));
  assign w_first = (r_cnt == '0);

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_acc  <= 32'h0;
      r_dout <= 32'h0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= validIn && w_last;
      if (validIn) begin
        if (w_last) begin
          // With a one-element vector the product passes through untouched.
          r_dout <= w_first ? dataIn : w_sum;
          r_cnt  <= '0;
        end else if (w_first) begin
          r_acc <= dataIn;
          r_cnt <= CNT_W'(1);
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign dataOut  = r_dout;
  assign validOut = r_vld;
  assign countOut = r_cnt;
  assign busyOut  = (r_cnt != '0);

endmodule

// File: tb/tb_fp_dot_accumulate.sv
// Directed-vector bench for fp_dot_accumulate (VEC_LEN=4) with hand-computed sums.
module tb_fp_dot_accumulate;

  localparam int CNT_W = 16;

  logic             clkIn = 1'b0;
  logic             rstIn = 1'b1;
  logic             validIn = 1'b0;
  logic [31:0]      dataIn = 32'h0;
  logic [31:0]      dataOut;
  logic             validOut;
  logic [CNT_W-1:0] countOut;
  logic             busyOut;

  int n_vec = 0;
  int n_err = 0;

  fp_dot_accumulate #(.VEC_LEN(4), .CNT_W(CNT_W)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .validIn(validIn), .dataIn(dataIn),
    .dataOut(dataOut), .validOut(validOut), .countOut(countOut), .busyOut(busyOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [31:0] d);
    @(negedge clkIn);
    validIn = v;
    dataIn  = d;
    @(posedge clkIn);
    #1;
    validIn = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] exp, input int max_gap);
    logic [31:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 32'hDEAD_BEEF);
        chk({tag, "_gapcnt"}, 32'(countOut), 32'(k));
        chk({tag, "_gapvld"}, 32'(validOut), 32'd0);
      end
      step(1'b1, v[k]);
      chk({tag, "_cnt"}, 32'(countOut), 32'((k + 1) % 4));
      chk({tag, "_busy"}, 32'(busyOut), (k < 3) ? 32'd1 : 32'd0);
      chk({tag, "_vld"}, 32'(validOut), (k == 3) ? 32'd1 : 32'd0);
    end
    chk({tag, "_sum"}, dataOut, exp);
    step(1'b0, 32'h0);
    chk({tag, "_pulse1"}, 32'(validOut), 32'd0);
    chk({tag, "_hold"}, dataOut, exp);
  endtask

  initial begin
    #12;
    chk("rst_data", dataOut, 32'h0);
    chk("rst_vld", 32'(validOut), 32'd0);
    chk("rst_cnt", 32'(countOut), 32'd0);
    chk("rst_busy", 32'(busyOut), 32'd0);
    @(negedge clkIn);
    rstIn = 1'b0;

    run_vec("sum1234", 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000, 0);
    run_vec("cancel",  32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h00000000, 0);
    run_vec("negzero", 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0);
    run_vec("tie_even", 32'h3F800000, 32'h33800000, 32'h0, 32'h0, 32'h3F800000, 0);
    run_vec("tie_odd",  32'h3F800001, 32'h33800000, 32'h0, 32'h0, 32'h3F800002, 0);
    run_vec("inf_nan",  32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 0);
    run_vec("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0, 32'h7F800000, 0);
    run_vec("denorm",   32'h00000001, 32'h0, 32'h0, 32'h0, 32'h00000000, 0);
    run_vec("inf_fin",  32'hFF800000, 32'h3F800000, 32'h40000000, 32'h0, 32'hFF800000, 0);
    run_vec("mixed",    32'h40A00000, 32'hBF800000, 32'h3F000000, 32'hC0000000, 32'h40200000, 0);
    run_vec("gaps",     32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000, 3);

    // Two vectors back to back with no idle cycle between them.
    step(1'b1, 32'h3F800000);
    step(1'b1, 32'h40000000);
    step(1'b1, 32'h40400000);
    step(1'b1, 32'h40800000);
    chk("b2b_v1", 32'(validOut), 32'd1);
    chk("b2b_d1", dataOut, 32'h41200000);
    step(1'b1, 32'h40000000);
    chk("b2b_gap_vld", 32'(validOut), 32'd0);
    chk("b2b_cnt", 32'(countOut), 32'd1);
    step(1'b1, 32'h40000000);
    step(1'b1, 32'h40000000);
    step(1'b1, 32'h40000000);
    chk("b2b_v2", 32'(validOut), 32'd1);
    chk("b2b_d2", dataOut, 32'h41000000);

    // Asynchronous reset between clock edges while a vector is partial.
    step(1'b1, 32'h3F800000);
    step(1'b1, 32'h40000000);
    chk("pre_rst_cnt", 32'(countOut), 32'd2);
    #2;
    rstIn = 1'b1;
    #1;
    chk("arst_data", dataOut, 32'h0);
    chk("arst_vld", 32'(validOut), 32'd0);
    chk("arst_cnt", 32'(countOut), 32'd0);
    chk("arst_busy", 32'(busyOut), 32'd0);
    @(negedge clkIn);
    rstIn = 1'b0;
    run_vec("post_rst", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_dot_accumulate.md
Name: fp_dot_accumulate

Overview:
- Streaming reduction stage directly downstream of floating_point_multiply.
- Consumes one IEEE-754 single-precision product per valid cycle and sums each group of VEC_LEN consecutive products with an internal single-cycle FP adder.
- Emits the group sum as one dot-product result.
- Output is checked by file_checker in the same bench topology used for the multiplier.

Parameters:
- VEC_LEN, 4, number of products per dot product; legal range 1..65535.
- CNT_W, 16, width of the element counter; must satisfy 2^CNT_W > VEC_LEN.

Ports:
- clkIn  input  1  system clock, rising edge
- rstIn  input  1  reset, asynchronous, active-high
- validIn  input  1  dataIn holds a product this cycle
- dataIn  input  32  product, IEEE-754 single
- dataOut  output  32  completed dot-product sum
- validOut  output  1  one-cycle pulse, dataOut valid
- countOut  output  CNT_W  products accumulated in the current vector (0..VEC_LEN-1)
- busyOut  output  1  high while a partial vector is held (countOut != 0)

Behaviour:
- Clock and reset: one clock, clkIn. Reset rstIn is asynchronous and active-high.
- Reset values: dataOut=0x00000000, validOut=0, countOut=0, busyOut=0, internal acc=0x00000000.
- Reset mid-vector: the partial sum and count are discarded. The first valid after release starts a new vector.
- No backpressure; one product is accepted on every validIn cycle. validIn low cycles (gaps) hold all state.
- States are implied by the counter:
  - IDLE/FIRST: count==0. A valid product loads acc=dataIn directly, with no add, so a -0 input is preserved. count becomes 1.
  - ACCUM: 0<count<VEC_LEN-1. A valid product sets acc=fp_add(acc,dataIn) and increments count.
  - LAST: count==VEC_LEN-1. A valid product registers dataOut=fp_add(acc,dataIn), pulses validOut, and resets count to 0.
- VEC_LEN==1: every valid product passes to dataOut unchanged (the FIRST and LAST conditions coincide).
- Latency: validOut asserts on the clock edge after the cycle carrying the last product of the vector (1 cycle).
- Back-to-back vectors run at full rate with no bubble. The first product of vector N+1 may arrive in the cycle right after the last product of vector N.
- dataOut holds its value between pulses. validOut is low except for the single result cycle.
- fp_add arithmetic rules:
  - Inputs with exponent 0 (denormals) are treated as signed zero. Denormal results flush to +0.
  - Align the smaller operand with guard, round and sticky bits. Round to nearest, ties to even.
  - x+(-x) = +0. (+0)+(-0) = +0. (-0)+(-0) = -0.
  - Exponent overflow gives ±inf (0x7F800000 / 0xFF800000).
  - Any NaN input, or inf+(-inf), gives canonical NaN 0x7FC00000.
  - inf plus a finite value gives that inf.
- A NaN or inf mid-vector propagates per the rules above through the remaining adds.
- countOut is a registered view of the internal counter. busyOut = (countOut != 0).

Test Plan:
- VEC_LEN=4; valid on 4 consecutive cycles with 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (1,2,3,4) -> one cycle later validOut=1 for exactly one cycle, dataOut=0x41200000 (10.0). countOut sequence 1,2,3,0.
- Cancellation: 0x3F800000, 0xBF800000, 0x3F800000, 0xBF800000 -> dataOut=0x00000000. Separately, four inputs of 0x80000000 -> dataOut=0x80000000.
- Rounding: 0x3F800000, 0x33800000 (2^-24), 0x00000000, 0x00000000 -> 0x3F800000 (tie to even). 0x3F800001, 0x33800000, 0, 0 -> 0x3F800002.
- Specials: 0x7F800000, 0xFF800000, 0x3F800000, 0x3F800000 -> 0x7FC00000. 0x7F7FFFFF, 0x7F7FFFFF, 0, 0 -> 0x7F800000. Denormal 0x00000001 plus three zeros -> 0x00000000.
- Gaps and back-to-back: the 1,2,3,4 vector sent with random validIn gaps gives the same 0x41200000. Eight consecutive valid products (1..4, then 4×0x40000000) -> pulses carrying 0x41200000 and then 0x41000000 (8.0), with no dropped products.
- Reset mid-vector: apply 1.0 and 2.0, assert rstIn asynchronously between clock edges -> all outputs go to reset values immediately. Then 4×0x3F800000 -> dataOut=0x40800000 (4.0).
